// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage,
// valid/ready on both sides, one operation per cycle when the sink keeps up.
module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int STAGES = WIDTH / BLOCK;

    // Operands travel with the beat; sum fills in one group per stage, low group first.
    typedef struct packed {
        logic             valid;
        logic             sub;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
    } stage_t;

    // Rank 0 captures the beat; rank k+1 holds it with group k resolved.
    stage_t stage_q [STAGES+1];
    stage_t stage_d [STAGES+1];
    logic   stall;
    logic   in_fire;

    // Flat sum-of-products carries: every c[i] is a direct AND/OR of g, p and the
    // group carry-in, so no carry ripples bit to bit inside the group.
    function automatic stage_t resolve(input stage_t s, input int k);
        stage_t           r;
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             term;
        logic             pp;
        r = s;
        g = s.a[k*BLOCK +: BLOCK] & s.b[k*BLOCK +: BLOCK];
        p = s.a[k*BLOCK +: BLOCK] ^ s.b[k*BLOCK +: BLOCK];
        for (int i = 0; i <= BLOCK; i++) begin
            term = 1'b0;
            pp   = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (pp & g[j]);
                pp   = pp & p[j];
            end
            c[i] = term | (pp & s.carry);
        end
        r.sum[k*BLOCK +: BLOCK] = p ^ c[BLOCK-1:0];
        r.carry                 = c[BLOCK];
        return r;
    endfunction

    always_comb begin
        stall    = stage_q[STAGES].valid && !out_ready;
        in_ready = !stall;
        in_fire  = in_valid && in_ready;

        // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
        stage_d[0] = '0;
        if (in_fire) begin
            stage_d[0].valid = 1'b1;
            stage_d[0].sub   = in_sub;
            stage_d[0].carry = in_cin ^ in_sub;
            stage_d[0].a     = in_a;
            stage_d[0].b     = in_sub ? ~in_b : in_b;
        end
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k+1] = resolve(stage_q[k], k);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; data fields are reset
    // with the valid bits so every output reads 0 straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k <= STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Bubbles carry all-zero data, so only the zero flag needs qualifying by valid.
    always_comb begin
        out_valid = stage_q[STAGES].valid;
        out_sum   = stage_q[STAGES].sum;
        out_cout  = stage_q[STAGES].carry ^ stage_q[STAGES].sub;
        out_ovf   = (stage_q[STAGES].a[WIDTH-1] == stage_q[STAGES].b[WIDTH-1]) &&
                    (stage_q[STAGES].sum[WIDTH-1] != stage_q[STAGES].a[WIDTH-1]);
        out_zero  = stage_q[STAGES].valid && (stage_q[STAGES].sum == '0);
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub: directed 32/8 vectors, backpressure stream,
// mid-flight reset, and a streamed sweep over 8/8, 16/4 and 64/16 instances.
`timescale 1ns/1ps
module tb_cla_pipe_addsub;

    typedef struct packed {
        logic        zero;
        logic        ovf;
        logic        cout;
        logic [63:0] sum;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } dvec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic        in_valid, in_ready, in_cin, in_sub;
    logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [31:0] in_a, in_b, out_sum;

    logic        sw_ready;
    logic        s8_in_valid, s8_in_ready, s8_cin, s8_sub, s8_out_valid, s8_cout, s8_ovf, s8_zero;
    logic [7:0]  s8_a, s8_b, s8_sum;
    logic        s16_in_valid, s16_in_ready, s16_cin, s16_sub, s16_out_valid, s16_cout, s16_ovf, s16_zero;
    logic [15:0] s16_a, s16_b, s16_sum;
    logic        s64_in_valid, s64_in_ready, s64_cin, s64_sub, s64_out_valid, s64_cout, s64_ovf, s64_zero;
    logic [63:0] s64_a, s64_b, s64_sum;

    cla_pipe_addsub #(.WIDTH(32), .BLOCK(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    cla_pipe_addsub #(.WIDTH(8), .BLOCK(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(s8_in_valid), .in_ready(s8_in_ready), .in_a(s8_a), .in_b(s8_b),
        .in_cin(s8_cin), .in_sub(s8_sub),
        .out_valid(s8_out_valid), .out_ready(sw_ready), .out_sum(s8_sum),
        .out_cout(s8_cout), .out_ovf(s8_ovf), .out_zero(s8_zero)
    );

    cla_pipe_addsub #(.WIDTH(16), .BLOCK(4)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(s16_in_valid), .in_ready(s16_in_ready), .in_a(s16_a), .in_b(s16_b),
        .in_cin(s16_cin), .in_sub(s16_sub),
        .out_valid(s16_out_valid), .out_ready(sw_ready), .out_sum(s16_sum),
        .out_cout(s16_cout), .out_ovf(s16_ovf), .out_zero(s16_zero)
    );

    cla_pipe_addsub #(.WIDTH(64), .BLOCK(16)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(s64_in_valid), .in_ready(s64_in_ready), .in_a(s64_a), .in_b(s64_b),
        .in_cin(s64_cin), .in_sub(s64_sub),
        .out_valid(s64_out_valid), .out_ready(sw_ready), .out_sum(s64_sum),
        .out_cout(s64_cout), .out_ovf(s64_ovf), .out_zero(s64_zero)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic on a w-bit slice of 64-bit operands.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub, input int w);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bb;
        logic [64:0] full;
        res_t        r;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am     = a & mask;
        bb     = (sub ? ~b : b) & mask;
        full   = {1'b0, am} + {1'b0, bb} + {64'd0, cin ^ sub};
        r.sum  = full[63:0] & mask;
        r.cout = full[w] ^ sub;
        r.ovf  = (am[w-1] == bb[w-1]) && (r.sum[w-1] != am[w-1]);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    function automatic res_t get32();
        return {out_zero, out_ovf, out_cout, 32'h0, out_sum};
    endfunction

    task automatic send_directed(input string tag, input dvec_t v);
        int   lat;
        res_t exp;
        exp       = {v.zero, v.ovf, v.cout, 32'h0, v.sum};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = v.a;
        in_b      = v.b;
        in_cin    = v.cin;
        in_sub    = v.sub;
        check({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check(tag, get32(), exp);
        step();
        check({tag, "_drained"}, out_valid, 0);
    endtask

    dvec_t dv [8];

    initial begin
        dv[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        dv[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        dv[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        dv[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        dv[4] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        dv[5] = '{32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0101, 1'b0, 1'b0, 1'b0};
        dv[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        dv[7] = '{32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0, 32'h0002_0000, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        sw_ready  = 1'b1;
        s8_in_valid = 1'b0;  s8_a = '0;  s8_b = '0;  s8_cin = 1'b0;  s8_sub = 1'b0;
        s16_in_valid = 1'b0; s16_a = '0; s16_b = '0; s16_cin = 1'b0; s16_sub = 1'b0;
        s64_in_valid = 1'b0; s64_a = '0; s64_b = '0; s64_cin = 1'b0; s64_sub = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_outputs", {out_valid, out_sum, out_cout, out_ovf, out_zero}, 0);
        check("reset_in_ready", in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            send_directed($sformatf("dir%0d", i), dv[i]);
        end

        // Backpressure stream against the reference model.
        begin
            res_t        exp_q [$];
            res_t        prev_out;
            res_t        exp;
            logic        prev_stall;
            logic        accepted;
            int          sent;
            int          got;
            sent       = 0;
            got        = 0;
            prev_stall = 1'b0;
            prev_out   = '0;
            in_valid   = 1'b1;
            in_a       = $urandom;
            in_b       = $urandom;
            in_cin     = 1'($urandom_range(0, 1));
            in_sub     = 1'($urandom_range(0, 1));
            for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                check("bp_in_ready", in_ready, !(out_valid && !out_ready));
                if (prev_stall) begin
                    check("bp_stall_valid", out_valid, 1);
                    check("bp_stall_hold", get32(), prev_out);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("bp_spurious", exp_q.size(), 1);
                    end else begin
                        exp = exp_q.pop_front();
                        check("bp_result", get32(), exp);
                    end
                    got++;
                end
                accepted = in_valid && in_ready;
                if (accepted) begin
                    exp_q.push_back(model({32'h0, in_a}, {32'h0, in_b}, in_cin, in_sub, 32));
                    sent++;
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = get32();
                step();
                if (accepted) begin
                    if (sent < 16) begin
                        in_a   = $urandom;
                        in_b   = $urandom;
                        in_cin = 1'($urandom_range(0, 1));
                        in_sub = 1'($urandom_range(0, 1));
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            check("bp_count", got, 16);
            check("bp_sent", sent, 16);
            check("bp_queue_empty", exp_q.size(), 0);
        end

        // Mid-flight reset: three beats in flight, then a one-cycle reset.
        out_ready = 1'b1;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 32'h1111_1111 * (i + 1);
            in_b     = 32'h0000_0001;
            in_cin   = 1'b0;
            in_sub   = 1'b0;
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        check("rst_outputs", {out_valid, out_sum, out_cout, out_ovf, out_zero}, 0);
        for (int i = 0; i < 6; i++) begin
            check("rst_flush_quiet", out_valid, 0);
            step();
        end
        send_directed("post_rst", dv[7]);

        // Streamed sweep: 8/8 (latency 1), 16/4 and 64/16 (latency 4), one beat per cycle.
        begin
            localparam int N = 24;
            res_t        exp8  [N];
            res_t        exp16 [N];
            res_t        exp64 [N];
            logic [63:0] a;
            logic [63:0] b;
            logic        cin;
            logic        sub;
            for (int t = 0; t < N + 5; t++) begin
                if (t >= 2 && t - 2 < N) begin
                    check("w8_valid", s8_out_valid, 1);
                    check("w8_res", {s8_zero, s8_ovf, s8_cout, 56'h0, s8_sum}, exp8[t-2]);
                end
                if (t >= 5) begin
                    check("w16_valid", s16_out_valid, 1);
                    check("w16_res", {s16_zero, s16_ovf, s16_cout, 48'h0, s16_sum}, exp16[t-5]);
                    check("w64_valid", s64_out_valid, 1);
                    check("w64_res", {s64_zero, s64_ovf, s64_cout, s64_sum}, exp64[t-5]);
                end
                if (t < N) begin
                    if (t < 8) begin
                        a   = t[0] ? '1 : '0;
                        b   = t[1] ? '1 : '0;
                        sub = t[2];
                        cin = t[0];
                    end else begin
                        a   = {$urandom, $urandom};
                        b   = {$urandom, $urandom};
                        sub = 1'($urandom_range(0, 1));
                        cin = 1'($urandom_range(0, 1));
                    end
                    exp8[t]  = model(a, b, cin, sub, 8);
                    exp16[t] = model(a, b, cin, sub, 16);
                    exp64[t] = model(a, b, cin, sub, 64);
                    s8_in_valid  = 1'b1; s8_a  = a[7:0];  s8_b  = b[7:0];  s8_cin  = cin; s8_sub  = sub;
                    s16_in_valid = 1'b1; s16_a = a[15:0]; s16_b = b[15:0]; s16_cin = cin; s16_sub = sub;
                    s64_in_valid = 1'b1; s64_a = a;       s64_b = b;       s64_cin = cin; s64_sub = sub;
                end else begin
                    s8_in_valid  = 1'b0;
                    s16_in_valid = 1'b0;
                    s64_in_valid = 1'b0;
                end
                step();
            end
            check("w8_idle", s8_out_valid, 0);
            check("w64_idle", s64_out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
